alu_subi_bist: RTL
==================

# alu_subi_bist

Synthesizable built-in self-test driver for the datapath ALU's subtract-immediate path. It is the initiator side of the ALU port: it drives operands and control, checks `Out`, `Z` and optionally `Ofl` each cycle against an internal golden model, and reports pass/fail. It sits beside the ALU in the execute stage and is enabled from test logic.

## Interface
- `N_VECTORS`, 1000: number of vectors checked per run; must be ≥ 2.
- `IMM`, 16'd5: immediate applied on `B`.
- `SEED`, 16'hACE1: LFSR seed; a value of 0 is replaced by 16'h0001.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE or DONE.
- `alu_A` out 16: operand A; registered.
- `alu_B` out 16: constant `IMM`.
- `alu_Op` out 4: constant 4'b0101 (SUB).
- `alu_Cin`, `alu_invA`, `alu_invB` out 1 each: constant 0.
- `alu_sign` out 1: constant 1.
- `alu_Out` in 16: ALU result; combinational from `alu_A` and `alu_B`.
- `alu_Z` in 1: ALU zero flag.
- `alu_Ofl` in 1: ALU overflow flag.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until `start` or `rst`.
- `pass` out 1: valid while `done`; 1 means zero errors.
- `err_count` out 16: number of failing vectors; saturates at 16'hFFFF.
- `first_fail_A` out 16: `alu_A` value of the first failing vector.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after the N_VECTORS-th check.
  - DONE → RUN on `start`.
  - `start` is ignored in RUN.
- Entering RUN:
  - Clear `err_count`, `first_fail_A`, `pass` and `done`.
  - Clear the vector counter and load the LFSR with `SEED`.
  - Set `alu_A` = `IMM`.
- Vector sequence:
  - Vector 0 = `IMM` (expected result 0, exercises Z).
  - Vector 1 = 16'h8000 (exercises Ofl for `IMM` > 0).
  - Vectors 2 and later = successive LFSR states.
  - LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0. It advances only once per vector, starting with vector 2.
- Golden model, all arithmetic mod 2^16:
  - R = `alu_A` − `IMM`
  - expZ = (R == 0)
  - expOfl = (A[15] ≠ B[15]) & (R[15] ≠ A[15])
- A vector fails if `alu_Out` ≠ R, or `alu_Z` ≠ expZ, or (macro only) `alu_Ofl` ≠ expOfl. A vector counts once even if several of these mismatch.
- On a failure:
  - `err_count` increments, saturating at 16'hFFFF.
  - If this is the first failure of the run, `first_fail_A` captures `alu_A`.

## Timing
- Reset values:
  - State IDLE; `alu_A` = 0; `busy` = `done` = `pass` = 0; `err_count` = 0; `first_fail_A` = 0.
  - LFSR = `SEED`; vector counter = 0.
  - Constant outputs hold their fixed values at all times.
- Run sequence:
  - `start` is sampled high at edge k. From edge k, `busy` = 1 and `alu_A` = vector 0.
  - At each edge k+1 … k+N_VECTORS, the block checks the vector presented during the preceding cycle, then loads the next vector.
  - At edge k+N_VECTORS the block makes its last check and enters DONE: `busy` = 0, `done` = 1, `pass` = (final `err_count` == 0, including the last check).
  - `busy` is therefore high for exactly N_VECTORS cycles.
- `alu_A` holds its last vector while in DONE.
- `rst` during RUN aborts the run the same edge; all outputs return to reset values. No partial results are retained.
- `start` in DONE at edge j behaves exactly like `start` from IDLE, and the run repeats the identical sequence.

## Configuration
- `ALU_SUBI_BIST_OFL_CHECK_EN`
  - Defined: `alu_Ofl` is compared against expOfl and is part of the fail condition.
  - Undefined: `alu_Ofl` is unused (left unconnected internally) and only `Out`/`Z` are checked.

## Structure
- Package `alu_bist_pkg` holds:
  - FSM state enum.
  - `OP_SUB` = 4'b0101.
  - LFSR tap mask 16'hB400.
  - `VEC_OFL` = 16'h8000.
- Sub-module `lfsr16`:
  - Inputs: `clk`, `rst`, `load`, `seed`, `adv`.
  - Output: `q`.
  - Same synchronous active-high reset as the parent.

## Test plan
- Correct ALU, `start` pulse → `busy` high exactly 1000 cycles, then `done` = 1, `pass` = 1, `err_count` = 0.
- ALU returns ~R every cycle → `err_count` = 1000, `first_fail_A` = 16'h0005, `pass` = 0.
- ALU `Z` stuck 0 → `pass` = 0, `first_fail_A` = 16'h0005, `err_count` ≥ 1.
- With the macro and `Ofl` stuck 0 → `first_fail_A` = 16'h8000. Without the macro → `pass` = 1.
- `rst` asserted at cycle 500 of a run → next cycle `busy` = 0, `err_count` = 0, `alu_A` = 0. A new `start` reproduces the identical `alu_A` sequence.
- `start` pulsed repeatedly during RUN → ignored, `busy` width is still 1000 cycles. `start` in DONE → counts clear and a new run begins.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU subtract-immediate BIST driver.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [3:0]  OP_SUB    = 4'b0101;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] VEC_OFL   = 16'h8000;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting left into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == '0) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/alu_subi_bist_lfsr16.sv
// 16-bit vector-source LFSR; a zero seed is replaced by 16'h0001.
module lfsr16
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= fix_seed(seed);
    end else if (adv) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/alu_subi_bist.sv
// BIST initiator for the ALU subtract-immediate path.
// Optional overflow checking: define ALU_SUBI_BIST_OFL_CHECK_EN.
module alu_subi_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned N_VECTORS = 1000,
  parameter logic [15:0] IMM       = 16'd5,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_Op,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_Z,
  input  logic        alu_Ofl,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_A
);

  state_t      state, state_nx;
  logic [31:0] vec_idx;
  logic [15:0] lfsr_q;
  logic        enter_run, check, last, adv;
  logic [15:0] r_exp, err_nx, vec_next;
  logic        z_exp, fail;

  assign alu_B    = IMM;
  assign alu_Op   = OP_SUB;
  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b1;

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    enter_run = 1'b0;
    check     = 1'b0;
    last      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx  = ST_RUN;
          enter_run = 1'b1;
        end
      end
      ST_RUN: begin
        check = 1'b1;
        if (vec_idx == 32'(N_VECTORS - 1)) begin
          last     = 1'b1;
          state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign r_exp = alu_A - IMM;
  assign z_exp = (r_exp == '0);

`ifdef ALU_SUBI_BIST_OFL_CHECK_EN
  logic ofl_exp;
  assign ofl_exp = (alu_A[15] != IMM[15]) && (r_exp[15] != alu_A[15]);
  assign fail    = check && ((alu_Out != r_exp) || (alu_Z != z_exp) || (alu_Ofl != ofl_exp));
`else
  logic unused_ofl;
  assign unused_ofl = alu_Ofl;
  assign fail       = check && ((alu_Out != r_exp) || (alu_Z != z_exp));
`endif

  assign err_nx = (fail && (err_count != '1)) ? err_count + 16'd1 : err_count;

  // The LFSR steps on the same edge that presents its new state, so alu_A
  // takes the combinational successor of the current LFSR value.
  assign adv      = check && !last && (vec_idx != '0);
  assign vec_next = (vec_idx == '0) ? VEC_OFL : lfsr_step(lfsr_q);

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (enter_run),
    .seed (SEED),
    .adv  (adv),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_A        <= '0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_fail_A <= '0;
      vec_idx      <= '0;
    end else if (enter_run) begin
      alu_A        <= IMM;
      pass         <= 1'b0;
      err_count    <= '0;
      first_fail_A <= '0;
      vec_idx      <= '0;
    end else if (check) begin
      err_count <= err_nx;
      if (fail && (err_count == '0)) begin
        first_fail_A <= alu_A;
      end
      if (last) begin
        pass <= (err_nx == '0);
      end else begin
        alu_A   <= vec_next;
        vec_idx <= vec_idx + 32'd1;
      end
    end
  end

endmodule
